// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a shared 4->1 single-bit mux: one-hot grant, select and valid, all registered.
// Optional forced release after HOLD_MAX grant cycles when MUX4_SCHED_TIMEOUT_EN is defined.
module mux4_rr_sched #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel_n;
  logic [3:0] gnt_n;
  logic       valid_n;

  logic [1:0] g;
  logic       hold_done;
  logic       release_c;
  logic [2:0] pk_idle;
  logic [2:0] pk_rel;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux4_rr_sched: HOLD_MAX must be in 1..255");
  end

`ifdef MUX4_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt, cnt_n;
  assign hold_done = (cnt == CW'(HOLD_MAX - 1));
`else
  assign hold_done = 1'b0;
`endif

  // Returns {found, index}: first set bit of v scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] v);
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (v[idx]) pick = {1'b1, idx};
    end
  endfunction

  assign g         = sel;
  assign release_c = !req[g] || hold_done;
  assign pk_idle   = pick(ptr, req);
  // Clearing a low req[g] changes nothing, and on timeout g stays in: it is scanned last either way.
  assign pk_rel    = pick(g + 2'd1, req);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    valid_n = valid;
`ifdef MUX4_SCHED_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
        if (pk_idle[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << pk_idle[1:0];
          sel_n   = pk_idle[1:0];
          valid_n = 1'b1;
`ifdef MUX4_SCHED_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      GRANT: begin
        if (!release_c) begin
`ifdef MUX4_SCHED_TIMEOUT_EN
          cnt_n = cnt + CW'(1);
`endif
        end else begin
          ptr_n = g + 2'd1;
          if (pk_rel[2]) begin
            gnt_n   = 4'b0001 << pk_rel[1:0];
            sel_n   = pk_rel[1:0];
            valid_n = 1'b1;
`ifdef MUX4_SCHED_TIMEOUT_EN
            cnt_n   = '0;
`endif
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      valid <= 1'b0;
`ifdef MUX4_SCHED_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      valid <= valid_n;
`ifdef MUX4_SCHED_TIMEOUT_EN
      cnt   <= cnt_n;
`endif
    end
  end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler sharing one 4->1 single-bit mux between four requesters.
- Requester i raises req[i]. The block grants one requester at a time and drives the mux select sel (= granted index), gnt and valid.
- Sits beside the mux; sel connects directly to the mux select and valid qualifies the mux output z.
- All outputs are registered.

Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles per requester when MUX4_SCHED_TIMEOUT_EN is defined. Legal range 1..255; ignored otherwise.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants the mux.
- gnt  output 4  one-hot grant; all-zero when idle.
- sel  output 2  mux select = index of granted requester.
- valid  output 1  high while a grant is active (gnt != 0).

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high (rst). Both are fixed decisions.
  - rst sampled high at a clk edge forces state=IDLE, gnt=4'b0000, valid=0, sel=2'b00, ptr=2'd0, cnt=0. This applies equally mid-grant; no partial transfer is remembered.
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - ptr[1:0] is the round-robin start index.
  - cnt is the hold counter, width $clog2(HOLD_MAX+1).
- Arbitration function pick(ptr, v):
  - Returns the first index i with v[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - Returns none if v=0.
- IDLE:
  - gnt=0, valid=0, sel holds its last value.
  - If req!=0 at an edge, go to GRANT with k=pick(ptr, req): gnt=1<<k, sel=k, valid=1, cnt=0.
  - Latency: request sampled at edge n -> grant visible after edge n.
- GRANT (granted index g=sel):
  - Each edge, release is true if req[g]=0, or (timeout feature only) cnt==HOLD_MAX-1.
  - If not released: stay, cnt increments. cnt never exceeds HOLD_MAX-1, so it never wraps.
  - On release: ptr <= g+1 (mod 4, 2'b11 wraps to 2'b00). Then compute v = req with bit g cleared if req[g]=0; v = req unchanged on timeout, so g competes last.
    - If pick(g+1, v) exists: direct handoff to the new index k the same edge (gnt, sel updated, cnt=0, valid stays 1, no bubble).
    - Else go to IDLE (gnt=0, valid=0).
- Release timing:
  - gnt/valid drop at the first edge where req[g] is sampled low.
  - Hence exactly one cycle with req[g]=0 and gnt[g]=1. Requesters must tolerate this.
- Simultaneous events:
  - Multiple new requests resolve by round-robin from ptr.
  - A requester that re-raises req in the release cycle is scheduled behind the others.
  - Changes on non-granted req bits during GRANT have no effect until release.
- Invariants: gnt is one-hot or zero; valid == |gnt; gnt[sel]==valid.

Optional Feature:
- Macro: MUX4_SCHED_TIMEOUT_EN.
- Defined: a grant is forcibly released after HOLD_MAX consecutive cycles (cnt==HOLD_MAX-1 at an edge) even while req[g]=1.
  - Release then rotates to the next pending requester.
  - If g is the only requester, it is re-granted immediately, with cnt reset to 0 and gnt unchanged.
- Undefined: no cnt register. A grant is held until req[g] drops, so a requester can own the mux indefinitely.

Test Plan:
- Reset: hold rst=1 for 2 edges with req=4'b1111 -> gnt=0000, valid=0, sel=00. Release rst with req=4'b0100 -> after the next edge gnt=0100, sel=10, valid=1.
- Fairness: req=4'b1111 held; each requester drops its req 3 cycles after its grant, then re-raises it -> grant order 0,1,2,3,0. Each handoff has no idle cycle and valid stays 1.
- Wrap-around: ptr=3 (after granting 2), req=4'b0001 -> gnt=0001, sel=00. Then drop req -> IDLE, ptr=1.
- Release overlap: grant to 1, drop req[1] mid-cycle -> gnt[1] stays high exactly one more cycle, then 0000. A new req=4'b0001 in that cycle -> gnt=0001 on the same edge.
- Mid-grant reset: during a grant to 3, assert rst for one edge -> gnt=0000, sel=00, ptr=0. With req=4'b1010 afterwards -> grant goes to 1, not 3.
- Timeout (MUX4_SCHED_TIMEOUT_EN, HOLD_MAX=4): req=4'b0011 held -> gnt alternates 0001 x4 cycles, 0010 x4 cycles, ... With only req=4'b0001 -> gnt stays 0001 continuously, valid never drops.
